// File: rtl/pong_comm_pkg.sv
// Shared message and packet definitions for the pong board-to-board link.
// The receive side imports this same package, so both ends agree on the framing.
package pong_comm_pkg;

  typedef enum logic [1:0] {
    BALL         = 2'd0,
    MISS         = 2'd1,
    NEW_GAME     = 2'd2,
    NEW_GAME_ACK = 2'd3
  } msg_type_t;

  localparam logic [3:0]  PKT_HDR_NIBBLE = 4'hA;
  localparam int unsigned PKT_BYTES      = 5;
  localparam int unsigned PAYLOAD_W      = 24;
  localparam int unsigned BYTE_IDX_W     = 3;

  typedef struct packed {
    msg_type_t              mtype;
    logic [PAYLOAD_W-1:0]   payload;
  } msg_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CTS = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_STOP     = 3'd4
  } tx_state_t;

  // Byte idx of the packet: header, payload high..low, then XOR checksum.
  function automatic logic [7:0] pkt_byte(input logic [BYTE_IDX_W-1:0] idx,
                                          input msg_t m);
    logic [7:0] hdr;
    hdr = {PKT_HDR_NIBBLE, m.mtype, 2'b00};
    case (idx)
      3'd0:    pkt_byte = hdr;
      3'd1:    pkt_byte = m.payload[23:16];
      3'd2:    pkt_byte = m.payload[15:8];
      3'd3:    pkt_byte = m.payload[7:0];
      default: pkt_byte = hdr ^ m.payload[23:16] ^ m.payload[15:8] ^ m.payload[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick_c on the last count.
// clear forces the count back to 0 so each state starts a fresh bit period.
module uart_baud_tick #(
  parameter int unsigned DIV = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick_c = (count == CNT_W'(DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// Serializes one typed 24-bit game message into a 5-byte 8N1 UART packet,
// pausing between bytes while the peer holds clear-to-send deasserted.
module uart_packet_tx #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [1:0]  msg_type,
  input  logic [23:0] msg_payload,
  input  logic        cts_n,
  output logic        uart_txd,
  output logic        busy
);

  import pong_comm_pkg::*;

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(PKT_BYTES - 1);

  tx_state_t             state;
  tx_state_t             state_next;
  msg_t                  msg_q;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic                  cts_meta;
  logic                  cts_sync;

  logic                  tick_c;
  logic                  accept_c;
  logic                  baud_clear_c;
  logic                  line_c;
  logic                  start_load_c;
  logic [BYTE_IDX_W-1:0] load_idx_c;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .clear  (baud_clear_c),
    .tick_c (tick_c)
  );

  // Two-flop synchronizer for the asynchronous peer flow-control line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    line_c       = 1'b1;
    accept_c     = msg_valid && msg_ready;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_next = ST_WAIT_CTS;
        end
      end
      ST_WAIT_CTS: begin
        if (!cts_sync) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        line_c = 1'b0;
        if (tick_c) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        line_c = shreg[0];
        if (tick_c && (bit_idx == 3'd7)) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        // With CTS already clear the CTS wait is satisfied in the stop bit's
        // last cycle, so consecutive bytes abut with no extra idle clock.
        if (tick_c) begin
          if (byte_idx == LAST_BYTE) begin
            state_next = ST_IDLE;
          end else if (!cts_sync) begin
            state_next = ST_START;
          end else begin
            state_next = ST_WAIT_CTS;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    baud_clear_c = (state_next != state) || (state == ST_IDLE) || (state == ST_WAIT_CTS);
    start_load_c = (state_next == ST_START) && (state != ST_START);
    load_idx_c   = (state == ST_STOP) ? (byte_idx + BYTE_IDX_W'(1)) : byte_idx;
  end

  // Message latch, byte/bit sequencing and registered line/handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msg_q     <= '0;
      byte_idx  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      uart_txd  <= 1'b1;
      msg_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      uart_txd  <= line_c;
      msg_ready <= (state_next == ST_IDLE);
      busy      <= (state_next != ST_IDLE);
      if (accept_c) begin
        msg_q    <= '{mtype: msg_type_t'(msg_type), payload: msg_payload};
        byte_idx <= '0;
      end
      if (start_load_c) begin
        shreg   <= pkt_byte(load_idx_c, msg_q);
        bit_idx <= '0;
      end else if ((state == ST_DATA) && tick_c) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if ((state == ST_STOP) && tick_c && (byte_idx != LAST_BYTE)) begin
        byte_idx <= byte_idx + BYTE_IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx at DIV = 10: a sampling line receiver checks framing
// and exact bit widths, and compares each byte against a queue of expected bytes.
module tb_uart_packet_tx;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned BAUD   = 100;

  logic        clock       = 1'b0;
  logic        reset       = 1'b1;
  logic        msg_valid   = 1'b0;
  logic        msg_ready;
  logic [1:0]  msg_type    = 2'd0;
  logic [23:0] msg_payload = 24'd0;
  logic        cts_n       = 1'b0;
  logic        uart_txd;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];

  uart_packet_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_type    (msg_type),
    .msg_payload (msg_payload),
    .cts_n       (cts_n),
    .uart_txd    (uart_txd),
    .busy        (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] model_byte(input logic [1:0] t, input logic [23:0] p, input int i);
    logic [7:0] h;
    h = {4'hA, t, 2'b00};
    case (i)
      0:       return h;
      1:       return p[23:16];
      2:       return p[15:8];
      3:       return p[7:0];
      default: return h ^ p[23:16] ^ p[15:8] ^ p[7:0];
    endcase
  endfunction

  task automatic send_msg(input logic [1:0] t, input logic [23:0] p, output int acc);
    int n;
    n = 0;
    @(negedge clock);
    while (msg_ready !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: msg_ready=%b, required 1", msg_ready);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(model_byte(t, p, i));
    msg_type    = t;
    msg_payload = p;
    msg_valid   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    msg_valid = 1'b0;
    acc = cyc;
  endtask

  // Receives one frame sampled at negedges and scores it against the queue.
  task automatic rx_byte(input string name, output int start_cyc);
    logic       s[100];
    logic [7:0] d;
    logic [7:0] e;
    bit         frame_ok;
    int         n;
    n = 0;
    @(negedge clock);
    while (uart_txd !== 1'b0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    start_cyc = cyc;
    if (uart_txd !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_start: line=%b, required start bit 0 within 3000 clocks", name, uart_txd);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    s[0] = uart_txd;
    for (int i = 1; i < 100; i++) begin
      @(negedge clock);
      s[i] = uart_txd;
    end
    frame_ok = 1'b1;
    for (int b = 0; b < 10; b++)
      for (int k = 1; k < 10; k++)
        if (s[b*10+k] !== s[b*10]) frame_ok = 1'b0;
    if (s[0] !== 1'b0 || s[90] !== 1'b1) frame_ok = 1'b0;
    for (int j = 0; j < 8; j++) d[j] = s[10 + 10*j];
    checks++;
    if (!frame_ok) begin
      errors++;
      $display("FAIL %s_frame: start=%b stop=%b widths_ok=0, required start=0 stop=1 and 10-clock bits",
               name, s[0], s[90]);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_data: got unexpected byte 0x%02h, required no byte", name, d);
    end else begin
      e = exp_q.pop_front();
      if (d !== e) begin
        errors++;
        $display("FAIL %s_data: got 0x%02h, required 0x%02h", name, d, e);
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (uart_txd !== 1'b1 || msg_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: txd=%b ready=%b busy=%b, required 1 0 0", uart_txd, msg_ready, busy);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (uart_txd !== 1'b1 || msg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: txd=%b ready=%b busy=%b, required 1 1 0", uart_txd, msg_ready, busy);
    end
  endtask

  task automatic test_single_ball;
    int acc, rdy, n;
    send_msg(2'd0, 24'h012345, acc);
    fork
      begin
        int st;
        for (int i = 0; i < 5; i++) rx_byte("ball", st);
      end
      begin
        n = 0;
        while (msg_ready !== 1'b1 && n < 1000) begin
          @(negedge clock);
          n++;
        end
        rdy = cyc;
      end
    join
    checks++;
    if (rdy - acc != 501) begin
      errors++;
      $display("FAIL ball_ready_latency: %0d clocks, required 501", rdy - acc);
    end
  endtask

  task automatic test_ack_checksum;
    int acc, st;
    send_msg(2'd3, 24'h000000, acc);
    for (int i = 0; i < 5; i++) rx_byte("ack", st);
  endtask

  task automatic test_flow_stall;
    int acc, p1s, fall, n;
    send_msg(2'd1, 24'h5AC30F, acc);
    fork
      begin
        int st;
        rx_byte("stall_h", st);
        rx_byte("stall_p2", st);
        rx_byte("stall_p1", p1s);
        rx_byte("stall_p0", st);
        rx_byte("stall_c", st);
      end
      begin
        n = 0;
        while (cyc < acc + 145 && n < 1000) begin
          @(negedge clock);
          n++;
        end
        cts_n = 1'b1;
        repeat (237) @(negedge clock);
        cts_n = 1'b0;
        fall = cyc;
      end
    join
    checks++;
    if (p1s < fall + 2 || p1s > fall + 4) begin
      errors++;
      $display("FAIL stall_resume: P1 start %0d clocks after cts_n fell, required 2..4", p1s - fall);
    end
  endtask

  task automatic test_back_to_back;
    int acc, rdy, n, lows;
    n = 0;
    @(negedge clock);
    while (msg_ready !== 1'b1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    msg_type    = 2'd1;
    msg_payload = 24'hDEAD01;
    msg_valid   = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(model_byte(2'd1, 24'hDEAD01, i));
    @(posedge clock);
    @(negedge clock);
    acc = cyc;
    checks++;
    if (msg_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hs_accept: ready=%b busy=%b, required 0 1", msg_ready, busy);
    end
    fork
      begin
        int st;
        for (int i = 0; i < 10; i++) rx_byte("hs", st);
      end
      begin
        repeat (50) @(negedge clock);
        msg_type    = 2'd2;
        msg_payload = 24'h00BEEF;
        n = 0;
        while (msg_ready !== 1'b1 && n < 1000) begin
          @(negedge clock);
          n++;
        end
        rdy = cyc;
        for (int i = 0; i < 5; i++) exp_q.push_back(model_byte(2'd2, 24'h00BEEF, i));
        @(posedge clock);
        @(negedge clock);
        msg_valid = 1'b0;
      end
    join
    checks++;
    if (rdy - acc != 501) begin
      errors++;
      $display("FAIL hs_ready_latency: %0d clocks, required 501", rdy - acc);
    end
    lows = 0;
    repeat (200) begin
      @(negedge clock);
      if (uart_txd !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL hs_quiet: %0d low samples, %0d bytes pending, required 0 and 0", lows, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_packet;
    int acc, st, n;
    send_msg(2'd2, 24'h112233, acc);
    rx_byte("mid_h", st);
    rx_byte("mid_p2", st);
    n = 0;
    while (cyc < acc + 215 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (uart_txd !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_low: txd=%b during P1 bit0, required 0", uart_txd);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (uart_txd !== 1'b1 || msg_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: txd=%b ready=%b busy=%b, required 1 0 0", uart_txd, msg_ready, busy);
    end
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_ready: ready=%b, required 1", msg_ready);
    end
    send_msg(2'd0, 24'hABCDEF, acc);
    for (int i = 0; i < 5; i++) rx_byte("mid_new", st);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ball();
    test_ack_checksum();
    test_flow_stall();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
